// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the 5-stage core pipeline sequencer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package hazard_ctrl_pkg;

  // Memory-wait tracking states of the sequencer
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_e;

  // x0 is hardwired to zero, so it never creates a dependency
  localparam logic [4:0] REG_ZERO = 5'd0;

  // RV32I major opcodes shared with the decoder
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;

  // True when a source operand that is actually read matches a real destination
  function automatic logic reg_match(input logic       use_src,
                                     input logic [4:0] src,
                                     input logic [4:0] dst);
    return use_src && (src == dst) && (dst != REG_ZERO);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts cycles with inc high, sticks at all-ones.
// Latency: count reflects an event one clock after it is seen.
// Backpressure: none; inc is sampled every cycle.
//
// Ports: clk, reset (async, active-high), inc (count enable), cnt (W-bit value)
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: per-cycle advance/hold/flush of PC, IF/ID, ID/EX, EX/MEM.
// Latency: control outputs are combinational from state and inputs (0 cycles).
// Backpressure: a pending data-memory access freezes the whole pipe; long waits halt it.
//
// Ports:
//   clk, reset              - clock, async active-high reset
//   id_rs1/rs2, id_use_*    - source registers read by the instruction in ID
//   ex_rd, ex_memread       - destination / load flag of the instruction in EX
//   ex_redirect             - EX resolved a taken branch or jump
//   mem_req, mem_ready      - data-memory handshake of the MEM stage
//   *_en, *_flush           - pipeline register load enables and NOP clears
//   halted                  - sticky memory-timeout halt
//   stall_cnt, flush_cnt    - saturating debug counters
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_redirect,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);

  state_e          state_q, state_d;
  logic [WC_W-1:0] wait_q, wait_d;

  logic freeze;
  logic loaduse;

  assign freeze  = mem_req & ~mem_ready;
  assign loaduse = ex_memread &
                   (reg_match(id_use_rs1, id_rs1, ex_rd) |
                    reg_match(id_use_rs2, id_rs2, ex_rd));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;

    case (state_q)
      RUN: begin
        // A zero-wait access (mem_req & mem_ready) never leaves RUN
        if (freeze) begin
          state_d = MEM_WAIT;
          wait_d  = WC_W'(1);
        end
      end
      MEM_WAIT: begin
        // A dropped request without ready is a protocol error; treat it as done
        if (mem_ready || !mem_req) begin
          state_d = RUN;
          wait_d  = '0;
        end else if (wait_q == WC_W'(MEM_TIMEOUT)) begin
          state_d = HALT;
        end else begin
          wait_d = wait_q + WC_W'(1);
        end
      end
      HALT: begin
        // Absorbing: only reset leaves HALT
      end
      default: begin
        state_d = RUN;
        wait_d  = '0;
      end
    endcase

    if (state_q == HALT || freeze) begin
      // Frozen EX means redirect/load-use are re-evaluated once memory answers
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
    end else if (ex_redirect) begin
      // The ID instruction is squashed, so a coincident load-use is moot
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (loaduse) begin
      // Hold PC and IF/ID, insert one bubble into ID/EX
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  assign halted = (state_q == HALT);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (~pc_en & (state_q != HALT)),
    .cnt   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (ifid_flush),
    .cnt   (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with an expected-control scoreboard.
// Latency: control outputs checked 1 time unit after inputs change.
// Backpressure: n/a.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  localparam logic [5:0] C_RUN    = 6'b110101;
  localparam logic [5:0] C_FREEZE = 6'b000000;
  localparam logic [5:0] C_REDIR  = 6'b111111;
  localparam logic [5:0] C_LU     = 6'b000111;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_redirect, mem_req, mem_ready;

  logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, halted;
  logic [31:0] stall_cnt, flush_cnt;

  logic        s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_exmem_en, s_halted;
  logic [3:0]  s_stall_cnt, s_flush_cnt;

  int checks = 0;
  int errors = 0;

  logic [5:0] exp_q[$];
  string      tag_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_redirect(ex_redirect),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush),
    .idex_en(s_idex_en), .idex_flush(s_idex_flush), .exmem_en(s_exmem_en),
    .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pop the oldest expected control word and compare against the DUT
  task automatic check_ctrl();
    logic [5:0] e;
    logic [5:0] o;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s ctrl observed=%b expected=%b", t, o, e);
    end
  endtask

  // Called at a negedge with inputs already applied; returns at the next negedge
  task automatic step(input logic [5:0] e, input string tag);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    check_ctrl();
    @(negedge clk);
  endtask

  task automatic idle();
    id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_rd = '0; ex_memread = 0; ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    ex_memread = 1; ex_rd = rd; id_rs1 = rd; id_use_rs1 = 1;
    id_rs2 = 5'd7; id_use_rs2 = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    #1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    idle();
    reset = 1;
    #2;
    exp_q.push_back(C_RUN); tag_q.push_back("reset_ctrl");
    check_ctrl();
    chk(32'(halted), 0, "reset_halted");
    chk(stall_cnt, 0, "reset_stall_cnt");
    chk(flush_cnt, 0, "reset_flush_cnt");
    @(negedge clk);
    reset = 0;

    // Load-use on rs1: one bubble, then release
    set_loaduse(5'd5);
    step(C_LU, "loaduse_stall");
    idle();
    step(C_RUN, "loaduse_release");
    chk(stall_cnt, 1, "loaduse_stall_cnt");

    // Load-use via rs2 only
    do_reset();
    ex_memread = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1; id_rs1 = 5'd9; id_use_rs1 = 0;
    step(C_LU, "loaduse_rs2");
    idle();
    // rs matches but operand not read
    ex_memread = 1; ex_rd = 5'd9; id_rs1 = 5'd9; id_use_rs1 = 0; id_rs2 = 5'd9; id_use_rs2 = 0;
    step(C_RUN, "loaduse_unused_src");

    // x0 destination never stalls
    do_reset();
    set_loaduse(5'd0);
    step(C_RUN, "x0_nostall");
    idle();
    step(C_RUN, "x0_after");
    chk(stall_cnt, 0, "x0_stall_cnt");

    // Redirect wins over coincident load-use
    do_reset();
    set_loaduse(5'd5);
    ex_redirect = 1;
    step(C_REDIR, "redirect_over_lu");
    idle();
    step(C_RUN, "redirect_after");
    chk(flush_cnt, 1, "redirect_flush_cnt");
    chk(stall_cnt, 0, "redirect_stall_cnt");

    // Three-cycle memory wait; redirect/load-use ignored while frozen
    do_reset();
    mem_req = 1; mem_ready = 0;
    step(C_FREEZE, "mem_wait1");
    ex_redirect = 1; set_loaduse(5'd3);
    step(C_FREEZE, "mem_wait2_ignore");
    ex_redirect = 0; ex_memread = 0;
    step(C_FREEZE, "mem_wait3");
    mem_ready = 1;
    step(C_RUN, "mem_release");
    chk(32'(u_dut.state_q), 32'(RUN), "mem_state_run");
    idle();
    mem_req = 1; mem_ready = 1;
    step(C_RUN, "mem_zero_wait");
    chk(stall_cnt, 3, "mem_stall_cnt");
    chk(flush_cnt, 0, "mem_flush_cnt");

    // Request dropped mid-wait counts as completion
    mem_req = 1; mem_ready = 0;
    step(C_FREEZE, "drop_wait");
    mem_req = 0;
    step(C_RUN, "drop_release");
    chk(32'(u_dut.state_q), 32'(RUN), "drop_state_run");

    // Timeout: wait_cnt climbs to 4, the next unanswered cycle halts
    do_reset();
    mem_req = 1; mem_ready = 0;
    for (int i = 0; i < 4; i++) step(C_FREEZE, "timeout_wait");
    chk(32'(halted), 0, "timeout_not_yet");
    step(C_FREEZE, "timeout_last");
    chk(32'(halted), 1, "timeout_halted");
    chk(stall_cnt, 5, "timeout_stall_cnt");
    mem_ready = 1;
    step(C_FREEZE, "halt_sticky_ready");
    mem_req = 0; mem_ready = 0; ex_redirect = 1;
    step(C_FREEZE, "halt_sticky_redirect");
    chk(32'(halted), 1, "halt_still");
    chk(stall_cnt, 5, "halt_no_stall_count");
    chk(flush_cnt, 0, "halt_no_flush_count");
    idle();
    reset = 1;
    #1;
    exp_q.push_back(C_RUN); tag_q.push_back("halt_reset_ctrl");
    check_ctrl();
    chk(32'(halted), 0, "halt_reset_halted");
    chk(stall_cnt, 0, "halt_reset_stall_cnt");
    @(negedge clk);
    reset = 0;

    // Saturation in the 4-bit build
    do_reset();
    set_loaduse(5'd12);
    for (int i = 0; i < 15; i++) step(C_LU, "sat_stall");
    chk(32'(s_stall_cnt), 15, "sat_stall_at_max");
    step(C_LU, "sat_stall_extra");
    chk(32'(s_stall_cnt), 15, "sat_stall_hold");
    chk(stall_cnt, 16, "wide_stall_cnt");
    idle();
    ex_redirect = 1;
    for (int i = 0; i < 17; i++) step(C_REDIR, "sat_flush");
    chk(32'(s_flush_cnt), 15, "sat_flush_hold");
    chk(32'(s_stall_cnt), 15, "sat_stall_final");
    chk(flush_cnt, 17, "wide_flush_cnt");
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
